// File: rtl/mha_score_core.sv
// Attention-score engine: computes S = Q x K^T for constant 4x4 Q and K on an
// output-stationary systolic array, then streams S out one row per cycle.
module mha_score_core #(
   parameter int                 N      = 4,
   parameter int                 DW     = 8,
   parameter int                 AW     = 19,
   parameter logic [N*N*DW-1:0]  Q_INIT = 128'h100F0E0D0C0B0A090807060504030201,
   parameter logic [N*N*DW-1:0]  K_INIT = 128'h01000000000100000000010000000001
) (
   input  logic            clk,
   input  logic            reset,
   output logic [N*AW-1:0] acc_out,
   output logic            out_valid,
   output logic [1:0]      out_row,
   output logic            done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FEED  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // Last feed step: N operand steps plus 2(N-1) cycles of skew, counted from 0.
   localparam logic [3:0] FEED_LAST = 4'(2*N+1);

   logic [1:0]      state_q,     state_d;
   logic [3:0]      cnt_q,       cnt_d;
   logic [N*AW-1:0] acc_out_q,   acc_out_d;
   logic            out_valid_q, out_valid_d;
   logic [1:0]      out_row_q,   out_row_d;
   logic            done_q,      done_d;

   logic [DW-1:0]   a_q   [N][N];
   logic [DW-1:0]   a_d   [N][N];
   logic [DW-1:0]   b_q   [N][N];
   logic [DW-1:0]   b_d   [N][N];
   logic [2*DW-1:0] prod  [N][N];
   logic [AW-1:0]   acc_q [N][N];
   logic [AW-1:0]   acc_d [N][N];

   logic [1:0]      row_sel;
   logic [N*AW-1:0] row_data;

   function automatic logic [DW-1:0] elem(input logic [N*N*DW-1:0] m, input int r, input int c);
      return m[(r*N+c)*DW +: DW];
   endfunction

   // a_d/b_d are both the next operand registers and the PE multiplier inputs.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         int k;
         k         = int'(cnt_q) - i;
         a_d[i][0] = '0;
         b_d[0][i] = '0;
         if (state_q == S_FEED && k >= 0 && k < N) begin
            a_d[i][0] = elem(Q_INIT, i, k);
            b_d[0][i] = elem(K_INIT, i, k);
         end
         for (int j = 1; j < N; j++) begin
            a_d[i][j] = a_q[i][j-1];
            b_d[j][i] = b_q[j-1][i];
         end
      end
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            prod[i][j]  = (2*DW)'(a_d[i][j]) * (2*DW)'(b_d[i][j]);
            acc_d[i][j] = acc_q[i][j] + AW'(prod[i][j]);
         end
      end
   end

   // Row presented on the next drain edge: row 0 when leaving FEED, else the following row.
   always_comb begin
      row_sel  = (state_q == S_FEED) ? 2'd0 : out_row_q + 2'd1;
      row_data = '0;
      for (int c = 0; c < N; c++) begin
         row_data[c*AW +: AW] = acc_q[row_sel][c];
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_out_d   = acc_out_q;
      out_valid_d = out_valid_q;
      out_row_d   = out_row_q;
      done_d      = done_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_FEED;
            cnt_d   = '0;
         end
         S_FEED: begin
            if (cnt_q == FEED_LAST) begin
               state_d     = S_DRAIN;
               out_valid_d = 1'b1;
               out_row_d   = 2'd0;
               acc_out_d   = row_data;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_DRAIN: begin
            if (out_row_q == 2'(N-1)) begin
               state_d     = S_DONE;
               out_valid_d = 1'b0;
               done_d      = 1'b1;
            end else begin
               out_row_d = row_sel;
               acc_out_d = row_data;
            end
         end
         default: ;
      endcase
   end

   // NOTE: the PE and skew arrays are real datapath state that a restart depends on, so
   // they are cleared by reset like any other flop; they are not a RAM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         acc_out_q   <= '0;
         out_valid_q <= 1'b0;
         out_row_q   <= '0;
         done_q      <= 1'b0;
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               a_q[i][j]   <= '0;
               b_q[i][j]   <= '0;
               acc_q[i][j] <= '0;
            end
         end
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_out_q   <= acc_out_d;
         out_valid_q <= out_valid_d;
         out_row_q   <= out_row_d;
         done_q      <= done_d;
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               a_q[i][j]   <= a_d[i][j];
               b_q[i][j]   <= b_d[i][j];
               acc_q[i][j] <= acc_d[i][j];
            end
         end
      end
   end

   assign acc_out   = acc_out_q;
   assign out_valid = out_valid_q;
   assign out_row   = out_row_q;
   assign done      = done_q;

endmodule

// File: tb/tb_mha_score_core.sv
// Scoreboard bench: four parameterisations of mha_score_core share clock and reset;
// expected rows are queued per instance and popped by a monitor on every valid row.
module tb_mha_score_core;

   localparam int NI = 4;

   typedef struct {
      logic [1:0]  row;
      logic [75:0] data;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [75:0] acc   [NI];
   logic        ov    [NI];
   logic [1:0]  orow  [NI];
   logic        dn    [NI];

   exp_t sb [NI][$];
   int   errors;
   int   checks;

   mha_score_core dut0 (
      .clk(clk), .reset(reset), .acc_out(acc[0]), .out_valid(ov[0]), .out_row(orow[0]), .done(dn[0])
   );

   mha_score_core #(.Q_INIT({16{8'hFF}}), .K_INIT({16{8'hFF}})) dut1 (
      .clk(clk), .reset(reset), .acc_out(acc[1]), .out_valid(ov[1]), .out_row(orow[1]), .done(dn[1])
   );

   mha_score_core #(.K_INIT({16{8'h01}})) dut2 (
      .clk(clk), .reset(reset), .acc_out(acc[2]), .out_valid(ov[2]), .out_row(orow[2]), .done(dn[2])
   );

   mha_score_core #(.Q_INIT('0)) dut3 (
      .clk(clk), .reset(reset), .acc_out(acc[3]), .out_valid(ov[3]), .out_row(orow[3]), .done(dn[3])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [75:0] pack4(input int c0, input int c1, input int c2, input int c3);
      return {19'(c3), 19'(c2), 19'(c1), 19'(c0)};
   endfunction

   // Hand-computed score rows for each instance.
   task automatic push_run();
      for (int r = 0; r < 4; r++) begin
         sb[0].push_back('{row: 2'(r), data: pack4(4*r+1, 4*r+2, 4*r+3, 4*r+4)});
         sb[1].push_back('{row: 2'(r), data: pack4(260100, 260100, 260100, 260100)});
         sb[2].push_back('{row: 2'(r), data: pack4(10+16*r, 10+16*r, 10+16*r, 10+16*r)});
         sb[3].push_back('{row: 2'(r), data: '0});
      end
   endtask

   task automatic flush();
      for (int i = 0; i < NI; i++) sb[i].delete();
   endtask

   task automatic check_cleared(input string tag);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("%s_acc%0d", tag, i), acc[i], '0);
         check($sformatf("%s_valid%0d", tag, i), 76'(ov[i]), '0);
         check($sformatf("%s_row%0d", tag, i), 76'(orow[i]), '0);
         check($sformatf("%s_done%0d", tag, i), 76'(dn[i]), '0);
      end
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Edge e counts active edges since release; outputs sampled 1 time unit after each.
   task automatic window(input int upto);
      for (int e = 1; e <= upto; e++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NI; i++) begin
            check($sformatf("valid_E%0d_d%0d", e, i), 76'(ov[i]), 76'(e >= 11 && e <= 14));
            check($sformatf("done_E%0d_d%0d", e, i), 76'(dn[i]), 76'(e >= 15));
         end
      end
   endtask

   task automatic check_hold_last(input string tag);
      check($sformatf("%s_hold0", tag), acc[0], pack4(13, 14, 15, 16));
      check($sformatf("%s_hold1", tag), acc[1], pack4(260100, 260100, 260100, 260100));
      check($sformatf("%s_hold2", tag), acc[2], pack4(58, 58, 58, 58));
      check($sformatf("%s_hold3", tag), acc[3], '0);
   endtask

   task automatic check_drained(input string tag);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("%s_rows_left%0d", tag, i), 76'(sb[i].size()), '0);
      end
   endtask

   // Monitor: pops the scoreboard whenever an instance presents a valid row.
   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (ov[i] === 1'b1) begin
            if (sb[i].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_row d%0d: got row %0d with no expected row queued", i, orow[i]);
            end else begin
               exp_t e;
               e = sb[i].pop_front();
               check($sformatf("out_row_d%0d", i), 76'(orow[i]), 76'(e.row));
               check($sformatf("acc_out_d%0d_r%0d", i, e.row), acc[i], e.data);
            end
         end
      end
   end

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b0;

      // Power-up with reset held for two edges.
      repeat (2) begin
         @(posedge clk);
         #1;
         check_cleared("por");
      end

      // Full uninterrupted run.
      push_run();
      release_reset();
      window(20);
      check_hold_last("run1");
      check_drained("run1");

      // Second run, interrupted by reset during DRAIN after row 1 appears.
      reset = 1'b0;
      #1;
      check_cleared("rst_done");
      push_run();
      release_reset();
      window(12);
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_cleared("rst_drain");
      flush();
      @(posedge clk);
      #1;
      check_cleared("rst_hold");

      // Re-run after the mid-operation reset must reproduce the same rows and timing.
      push_run();
      release_reset();
      window(20);
      check_hold_last("run3");
      check_drained("run3");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
